otter_lsu_split: RTL and testbench

- Load/store initiator for the OTTER data-memory port (port 2). It sits between the multicycle core's memory stage and the dual-port memory.
- Accepts byte, half and word loads/stores at any alignment and issues only word-aligned, word-sized memory accesses.
- Accesses that span two words become two reads. Sub-word and misaligned stores become read-modify-write sequences.
- Loads return extracted, sign/zero-extended data on a single-cycle response pulse.

---
 rtl/otter_lsu_split.sv | 194 +++++++++++++++++++
 tb/tb_otter_lsu_split.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_lsu_split.sv
// OTTER port-2 load/store initiator: word-only memory accesses, split/RMW.
// Optional LSU_ALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module otter_lsu_split #(
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_READ2,
  output logic        MEM_WRITE2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic [2:0] {
    IDLE, RD0, CAP0, RD1, CAP1, WR0, WR1, DONE
  } state_t;

  state_t state, nxt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] w0, w1;

  function automatic logic [3:0] nmask(input logic [1:0] size);
    unique case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic spans(input logic [1:0] off,
                                 input logic [1:0] size);
    logic [2:0] nb;
    nb = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
    return ({1'b0, off} + nb) > 3'd4;
  endfunction

  function automatic logic bad(input logic [31:0] addr,
                               input logic [1:0]  size);
    logic        mmio;
    logic        mis;
    logic [31:0] w1a;
    mmio = addr >= IO_BASE;
    w1a  = {addr[31:2], 2'b00} + 32'd4;
`ifdef LSU_ALIGN_TRAP_EN
    mis  = (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'd0);
`else
    mis  = 1'b0;
`endif
    return (size == 2'd3) || mis ||
           (mmio && (size != 2'd2 || addr[1:0] != 2'd0)) ||
           (!mmio && spans(addr[1:0], size) && w1a >= IO_BASE);
  endfunction

  logic [1:0]  off_q;
  logic        span_q;
  logic [31:0] w0a, w1a;
  logic [63:0] shifted, wide, merged;
  logic [7:0]  bm8;
  logic [31:0] ldata;

  assign off_q  = addr_q[1:0];
  assign span_q = spans(off_q, size_q);
  assign w0a    = {addr_q[31:2], 2'b00};
  assign w1a    = w0a + 32'd4;

  always_comb begin
    shifted = {w1, w0} >> {off_q, 3'b000};
    wide    = {32'd0, wdata_q} << {off_q, 3'b000};
    bm8     = {4'd0, nmask(size_q)} << off_q;
    merged  = {w1, w0};
    for (int i = 0; i < 8; i++)
      if (bm8[i]) merged[8*i +: 8] = wide[8*i +: 8];
    unique case (size_q)
      2'd0: ldata = sign_q ? {24'd0, shifted[7:0]}
                           : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: ldata = sign_q ? {16'd0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
      default: ldata = shifted[31:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      w0      <= '0;
      w1      <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && REQ_VALID) begin
        we_q    <= REQ_WE;
        addr_q  <= REQ_ADDR;
        size_q  <= REQ_SIZE;
        sign_q  <= REQ_SIGN;
        wdata_q <= REQ_WDATA;
        err_q   <= bad(REQ_ADDR, REQ_SIZE);
      end
      if (state == CAP0) w0 <= MEM_DOUT2;
      // Spanning stores skip CAP1: the w1 read data is taken during WR0.
      if (state == CAP1 || (state == WR0 && span_q))
        w1 <= MEM_DOUT2;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (REQ_VALID) begin
        if (bad(REQ_ADDR, REQ_SIZE))
          nxt = DONE;
        else if (REQ_WE && REQ_SIZE == 2'd2 && REQ_ADDR[1:0] == 2'd0)
          nxt = WR0;
        else
          nxt = RD0;
      end
      RD0:  nxt = CAP0;
      CAP0: nxt = span_q ? RD1 : (we_q ? WR0 : DONE);
      RD1:  nxt = we_q ? WR0 : CAP1;
      CAP1: nxt = DONE;
      WR0:  nxt = span_q ? WR1 : DONE;
      WR1:  nxt = DONE;
      DONE: nxt = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    RSP_RDATA  = '0;
    RSP_ERR    = 1'b0;
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_READ2  = 1'b0;
    MEM_WRITE2 = 1'b0;
    MEM_SIZE   = RST ? 2'd0 : 2'd2;
    MEM_SIGN   = 1'b0;
    if (!RST) begin
      unique case (state)
        IDLE: REQ_READY = 1'b1;
        RD0: begin
          MEM_ADDR2 = w0a;
          MEM_READ2 = 1'b1;
        end
        CAP0: MEM_ADDR2 = w0a;
        RD1: begin
          MEM_ADDR2 = w1a;
          MEM_READ2 = 1'b1;
        end
        CAP1: MEM_ADDR2 = w1a;
        WR0: begin
          MEM_ADDR2  = w0a;
          MEM_DIN2   = merged[31:0];
          MEM_WRITE2 = 1'b1;
        end
        WR1: begin
          MEM_ADDR2  = w1a;
          MEM_DIN2   = merged[63:32];
          MEM_WRITE2 = 1'b1;
        end
        DONE: begin
          RSP_VALID = 1'b1;
          RSP_ERR   = err_q;
          RSP_RDATA = (err_q || we_q) ? 32'd0 : ldata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu_split.sv
// Directed bench for otter_lsu_split with a word-addressed memory model.
module tb_otter_lsu_split;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [1:0]  REQ_SIZE = '0;
  logic        REQ_SIGN = 1'b0;
  logic [31:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_READ2;
  logic        MEM_WRITE2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2 = '0;

  otter_lsu_split dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:1023];
  logic [31:0] mmio_last = '0;
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          rsp_cnt = 0;
  int          both_cnt = 0;

  always @(posedge CLK) begin
    if (MEM_READ2) begin
      rd_q.push_back(MEM_ADDR2);
      MEM_DOUT2 <= (MEM_ADDR2 >= 32'h11000000) ? 32'h0
                                               : mem[MEM_ADDR2[11:2]];
    end
    if (MEM_WRITE2) begin
      wa_q.push_back(MEM_ADDR2);
      wd_q.push_back(MEM_DIN2);
      if (MEM_ADDR2 >= 32'h11000000) mmio_last = MEM_DIN2;
      else mem[MEM_ADDR2[11:2]] = MEM_DIN2;
    end
    if (RSP_VALID) rsp_cnt++;
    if (MEM_READ2 && MEM_WRITE2) both_cnt++;
  end

  int          errors = 0;
  int          checks = 0;
  int          lat;
  logic [31:0] r_data;
  logic        r_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] wd);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    chk("ready_before", {31'd0, REQ_READY}, 32'd1);
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = a;
    REQ_SIZE  = sz;
    REQ_SIGN  = sg;
    REQ_WDATA = wd;
    step();
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 20) begin
      step();
      lat++;
    end
    r_data = RSP_RDATA;
    r_err  = RSP_ERR;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    step();
    step();
    chk("rst_ready", {31'd0, REQ_READY}, 32'd0);
    chk("rst_size", {30'd0, MEM_SIZE}, 32'd0);
    chk("rst_rsp", {31'd0, RSP_VALID}, 32'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, REQ_READY}, 32'd1);
    step();

    mem[32'h100 >> 2] = 32'hDEADBEEF;
    req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    chk("lw_lat", lat, 3);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err", {31'd0, r_err}, 32'd0);
    chk("lw_nrd", rd_q.size(), 1);
    chk("lw_rd0", rd_q[0], 32'h100);
    chk("lw_nwr", wa_q.size(), 0);

    mem[32'h100 >> 2] = 32'h88776655;
    mem[32'h104 >> 2] = 32'h443322F1;
    req(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
    chk("lb_data", r_data, 32'hFFFFFF88);
    req(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
    chk("lbu_data", r_data, 32'h00000088);

    req(1'b0, 32'h103, 2'd1, 1'b0, 32'h0);
`ifdef LSU_ALIGN_TRAP_EN
    chk("lh_span_err", {31'd0, r_err}, 32'd1);
    chk("lh_span_lat", lat, 1);
    chk("lh_span_nrd", rd_q.size(), 0);
`else
    chk("lh_span_lat", lat, 5);
    chk("lh_span_data", r_data, 32'hFFFFF188);
    chk("lh_span_nrd", rd_q.size(), 2);
    chk("lh_span_rd0", rd_q[0], 32'h100);
    chk("lh_span_rd1", rd_q[1], 32'h104);
    req(1'b0, 32'h103, 2'd1, 1'b1, 32'h0);
    chk("lhu_span_data", r_data, 32'h0000F188);
`endif

    mem[32'h100 >> 2] = 32'h11223344;
    mem[32'h104 >> 2] = 32'h55667788;
    req(1'b1, 32'h102, 2'd0, 1'b0, 32'hAB);
    chk("sb_lat", lat, 4);
    chk("sb_nrd", rd_q.size(), 1);
    chk("sb_nwr", wa_q.size(), 1);
    chk("sb_wa", wa_q[0], 32'h100);
    chk("sb_wd", wd_q[0], 32'h11AB3344);
    chk("sb_mem104", mem[32'h104 >> 2], 32'h55667788);
    chk("sb_rdata", r_data, 32'h0);

    mem[32'h100 >> 2] = 32'h11223344;
    req(1'b1, 32'h101, 2'd2, 1'b0, 32'hCAFEBABE);
`ifdef LSU_ALIGN_TRAP_EN
    chk("sw_span_err", {31'd0, r_err}, 32'd1);
    chk("sw_span_lat", lat, 1);
    chk("sw_span_nacc", rd_q.size() + wa_q.size(), 0);
`else
    chk("sw_span_lat", lat, 6);
    chk("sw_span_nwr", wa_q.size(), 2);
    chk("sw_span_wa0", wa_q[0], 32'h100);
    chk("sw_span_wd0", wd_q[0], 32'hFEBABE44);
    chk("sw_span_wa1", wa_q[1], 32'h104);
    chk("sw_span_wd1", wd_q[1], 32'h556677CA);
`endif

    req(1'b1, 32'h11000004, 2'd2, 1'b0, 32'h5);
    chk("mmio_sw_lat", lat, 2);
    chk("mmio_sw_nrd", rd_q.size(), 0);
    chk("mmio_sw_nwr", wa_q.size(), 1);
    chk("mmio_sw_wa", wa_q[0], 32'h11000004);
    chk("mmio_sw_val", mmio_last, 32'h5);

    req(1'b0, 32'h11000002, 2'd2, 1'b0, 32'h0);
    chk("mmio_mis_err", {31'd0, r_err}, 32'd1);
    chk("mmio_mis_lat", lat, 1);
    chk("mmio_mis_nacc", rd_q.size() + wa_q.size(), 0);

    req(1'b0, 32'h100, 2'd3, 1'b0, 32'h0);
    chk("size3_err", {31'd0, r_err}, 32'd1);
    chk("size3_rdata", r_data, 32'h0);

    req(1'b0, 32'h10FFFFFF, 2'd1, 1'b0, 32'h0);
    chk("cross_err", {31'd0, r_err}, 32'd1);
    chk("cross_nacc", rd_q.size() + wa_q.size(), 0);

    mem[32'h100 >> 2] = 32'h11223344;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 32'h100;
    REQ_SIZE  = 2'd0;
    REQ_WDATA = 32'hAB;
    step();
    REQ_VALID = 1'b0;
    chk("abort_rd0", {31'd0, MEM_READ2}, 32'd1);
    step();
    begin
      int base;
      base = rsp_cnt;
      RST = 1'b1;
      #1;
      chk("abort_outs", {29'd0, MEM_WRITE2, RSP_VALID, REQ_READY}, 32'd0);
      step();
      step();
      RST = 1'b0;
      #1;
      chk("abort_ready", {31'd0, REQ_READY}, 32'd1);
      step();
      step();
      step();
      chk("abort_nwr", wa_q.size(), 0);
      chk("abort_rsp", rsp_cnt - base, 0);
      chk("abort_mem", mem[32'h100 >> 2], 32'h11223344);
    end

    chk("strobe_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
